// File: rtl/calc_req_scheduler.sv
// Purpose : captures two-cycle requests on four ports and round-robins them onto the add/sub and shift units
// Latency : cmd edge E0 -> dispatch registered at E2; unit done at Ed -> out_respN registered at Ed
// Backpr. : none; one outstanding request per port, extra cmds on a busy port are dropped silently
// Ports   : c_clk/reset; reqN_cmd_in/reqN_data_in (N=1..4); out_respN/out_dataN;
//           au_*/su_* dispatch (valid, cmd, op1, op2, tag) and return (done, done_tag, resp, data)
module calc_req_scheduler #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 2
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req1_cmd_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [DATA_W-1:0] req1_data_in,
  input  logic [DATA_W-1:0] req2_data_in,
  input  logic [DATA_W-1:0] req3_data_in,
  input  logic [DATA_W-1:0] req4_data_in,
  output logic [1:0]        out_resp1,
  output logic [1:0]        out_resp2,
  output logic [1:0]        out_resp3,
  output logic [1:0]        out_resp4,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [DATA_W-1:0] out_data4,
  output logic              au_valid,
  output logic [3:0]        au_cmd,
  output logic [DATA_W-1:0] au_op1,
  output logic [DATA_W-1:0] au_op2,
  output logic [TAG_W-1:0]  au_tag,
  input  logic              au_done,
  input  logic [TAG_W-1:0]  au_done_tag,
  input  logic [1:0]        au_resp,
  input  logic [DATA_W-1:0] au_data,
  output logic              su_valid,
  output logic [3:0]        su_cmd,
  output logic [DATA_W-1:0] su_op1,
  output logic [DATA_W-1:0] su_op2,
  output logic [TAG_W-1:0]  su_tag,
  input  logic              su_done,
  input  logic [TAG_W-1:0]  su_done_tag,
  input  logic [1:0]        su_resp,
  input  logic [DATA_W-1:0] su_data
);

  typedef enum logic [1:0] {ST_IDLE, ST_OP2, ST_QUEUED, ST_INFLIGHT} state_e;

  // Unit index 0 = add/sub, 1 = shift.
  function automatic logic cmd_is_unit(input logic [3:0] cmd, input logic unit);
    if (!unit) return (cmd == 4'd1) || (cmd == 4'd2);
    return (cmd == 4'd5) || (cmd == 4'd6);
  endfunction

  // One-hot grant of the first requester at or after ptr, wrapping 3 -> 0.
  function automatic logic [3:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [3:0] gnt;
    logic       found;
    logic [1:0] idx;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  // Port-indexed views of the flat ports.
  logic [3:0]        req_cmd [4];
  logic [DATA_W-1:0] req_dat [4];
  logic              done_v    [2];
  logic [TAG_W-1:0]  done_tag  [2];
  logic [1:0]        done_resp [2];
  logic [DATA_W-1:0] done_dat  [2];

  assign req_cmd[0] = req1_cmd_in;   assign req_dat[0] = req1_data_in;
  assign req_cmd[1] = req2_cmd_in;   assign req_dat[1] = req2_data_in;
  assign req_cmd[2] = req3_cmd_in;   assign req_dat[2] = req3_data_in;
  assign req_cmd[3] = req4_cmd_in;   assign req_dat[3] = req4_data_in;
  assign done_v[0] = au_done;  assign done_tag[0] = au_done_tag;
  assign done_resp[0] = au_resp;  assign done_dat[0] = au_data;
  assign done_v[1] = su_done;  assign done_tag[1] = su_done_tag;
  assign done_resp[1] = su_resp;  assign done_dat[1] = su_data;

  // Per-port request state
  state_e            st_q   [4], st_d   [4];
  logic [3:0]        cmd_q  [4], cmd_d  [4];
  logic [DATA_W-1:0] op1_q  [4], op1_d  [4];
  logic [DATA_W-1:0] op2_q  [4], op2_d  [4];
  logic [1:0]        resp_q [4], resp_d [4];
  logic [DATA_W-1:0] rdat_q [4], rdat_d [4];

  // Per-unit arbitration and dispatch registers
  logic [1:0]        ptr_q  [2], ptr_d  [2];
  logic              vld_q  [2], vld_d  [2];
  logic [3:0]        dcmd_q [2], dcmd_d [2];
  logic [DATA_W-1:0] dop1_q [2], dop1_d [2];
  logic [DATA_W-1:0] dop2_q [2], dop2_d [2];
  logic [TAG_W-1:0]  dtag_q [2], dtag_d [2];

  logic [3:0] unit_req [2];
  logic [3:0] unit_gnt [2];

  always_comb begin
    for (int u = 0; u < 2; u++) begin
      unit_req[u] = '0;
      for (int p = 0; p < 4; p++) begin
        unit_req[u][p] = (st_q[p] == ST_QUEUED) && cmd_is_unit(cmd_q[p], u == 1);
      end
      unit_gnt[u] = rr_pick(unit_req[u], ptr_q[u]);
    end
  end

  always_comb begin
    st_d  = st_q;
    cmd_d = cmd_q;
    op1_d = op1_q;
    op2_d = op2_q;
    ptr_d = ptr_q;
    for (int p = 0; p < 4; p++) begin
      resp_d[p] = 2'b00;
      rdat_d[p] = '0;
    end
    for (int u = 0; u < 2; u++) begin
      vld_d[u]  = 1'b0;
      dcmd_d[u] = '0;
      dop1_d[u] = '0;
      dop2_d[u] = '0;
      dtag_d[u] = '0;
    end

    // Dispatch: a granted QUEUED port moves to INFLIGHT this edge.
    for (int u = 0; u < 2; u++) begin
      for (int p = 0; p < 4; p++) begin
        if (unit_gnt[u][p]) begin
          vld_d[u]  = 1'b1;
          dcmd_d[u] = cmd_q[p];
          dop1_d[u] = op1_q[p];
          dop2_d[u] = op2_q[p];
          dtag_d[u] = TAG_W'(p);
          ptr_d[u]  = 2'(p + 1);
          st_d[p]   = ST_INFLIGHT;
        end
      end
    end

    // Return: only accepted for a port in flight on that same unit.
    for (int u = 0; u < 2; u++) begin
      for (int p = 0; p < 4; p++) begin
        if (done_v[u] && done_tag[u] == TAG_W'(p) &&
            st_q[p] == ST_INFLIGHT && cmd_is_unit(cmd_q[p], u == 1)) begin
          resp_d[p] = done_resp[u];
          rdat_d[p] = done_dat[u];
          st_d[p]   = ST_IDLE;
        end
      end
    end

    // Capture; cmd inputs outside IDLE are ignored.
    for (int p = 0; p < 4; p++) begin
      case (st_q[p])
        ST_IDLE: begin
          if (req_cmd[p] != 4'd0) begin
            cmd_d[p] = req_cmd[p];
            op1_d[p] = req_dat[p];
            st_d[p]  = ST_OP2;
          end
        end
        ST_OP2: begin
          op2_d[p] = req_dat[p];
          if (cmd_is_unit(cmd_q[p], 1'b0) || cmd_is_unit(cmd_q[p], 1'b1)) begin
            st_d[p] = ST_QUEUED;
          end else begin
            st_d[p]   = ST_IDLE;
            resp_d[p] = 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        st_q[p]   <= ST_IDLE;
        cmd_q[p]  <= '0;
        op1_q[p]  <= '0;
        op2_q[p]  <= '0;
        resp_q[p] <= '0;
        rdat_q[p] <= '0;
      end
      for (int u = 0; u < 2; u++) begin
        ptr_q[u]  <= '0;
        vld_q[u]  <= 1'b0;
        dcmd_q[u] <= '0;
        dop1_q[u] <= '0;
        dop2_q[u] <= '0;
        dtag_q[u] <= '0;
      end
    end else begin
      st_q   <= st_d;
      cmd_q  <= cmd_d;
      op1_q  <= op1_d;
      op2_q  <= op2_d;
      resp_q <= resp_d;
      rdat_q <= rdat_d;
      ptr_q  <= ptr_d;
      vld_q  <= vld_d;
      dcmd_q <= dcmd_d;
      dop1_q <= dop1_d;
      dop2_q <= dop2_d;
      dtag_q <= dtag_d;
    end
  end

  assign out_resp1 = resp_q[0];  assign out_data1 = rdat_q[0];
  assign out_resp2 = resp_q[1];  assign out_data2 = rdat_q[1];
  assign out_resp3 = resp_q[2];  assign out_data3 = rdat_q[2];
  assign out_resp4 = resp_q[3];  assign out_data4 = rdat_q[3];

  assign au_valid = vld_q[0];  assign au_cmd = dcmd_q[0];  assign au_tag = dtag_q[0];
  assign au_op1   = dop1_q[0]; assign au_op2 = dop2_q[0];
  assign su_valid = vld_q[1];  assign su_cmd = dcmd_q[1];  assign su_tag = dtag_q[1];
  assign su_op1   = dop1_q[1]; assign su_op2 = dop2_q[1];

endmodule
